// File: rtl/nlp_update_queue.sv
// Two per-source update FIFOs (backend, IF3) feeding the next-line predictor
// through one valid/ready port; the backend queue always wins the port.

module nlp_uq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_target,
  input  logic        push_taken,
  input  logic        pop,
  output logic        nonempty,
  output logic [31:0] head_pc,
  output logic [31:0] head_target,
  output logic        head_taken,
  output logic [15:0] drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]   pc_mem     [DEPTH];
  logic [31:0]   target_mem [DEPTH];
  logic          taken_mem  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;
  logic [PW:0]   cnt;
  logic          tail_popped;
  logic          coalesce;
  logic          enq;
  logic          drop;

  assign last        = tail - PW'(1);
  assign nonempty    = (cnt != '0);
  // With one entry the tail is the head; if it leaves this cycle it cannot be merged into.
  assign tail_popped = pop && (cnt == (PW+1)'(1));
  assign coalesce    = push && nonempty && (pc_mem[last] == push_pc) && !tail_popped;
  assign enq         = push && !coalesce && ((cnt != FULL_CNT) || pop);
  assign drop        = push && !coalesce && !enq;

  assign head_pc     = pc_mem[head];
  assign head_target = target_mem[head];
  assign head_taken  = taken_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      if (enq) tail <= tail + PW'(1);
      case ({enq, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      if (coalesce) begin
        target_mem[last] <= push_target;
        taken_mem[last]  <= push_taken;
      end
      if (enq) begin
        pc_mem[tail]     <= push_pc;
        target_mem[tail] <= push_target;
        taken_mem[tail]  <= push_taken;
      end
    end
  end
endmodule

// Handshake: an update transfers on a rising edge where upd_valid && upd_ready;
// upd_valid never waits on upd_ready, and upd_ready is ignored while upd_valid=0.
module nlp_update_queue #(
  parameter int BK_DEPTH  = 4,
  parameter int IF3_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if3_valid,
  input  logic [31:0] if3_pc,
  input  logic [31:0] if3_target,
  input  logic        if3_taken,
  input  logic        bk_valid,
  input  logic [31:0] bk_pc,
  input  logic [31:0] bk_target,
  input  logic        bk_taken,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_from_bk,
  input  logic        upd_ready,
  output logic [15:0] if3_drop_cnt,
  output logic [15:0] bk_drop_cnt
);
  logic        bk_ne, if3_ne;
  logic        bk_pop, if3_pop;
  logic [31:0] bk_h_pc, bk_h_target, if3_h_pc, if3_h_target;
  logic        bk_h_taken, if3_h_taken;

  assign bk_pop  = bk_ne && upd_ready;
  assign if3_pop = !bk_ne && if3_ne && upd_ready;

  nlp_uq_fifo #(.DEPTH(BK_DEPTH)) u_bk_q (
    .clk(clk), .rst(rst), .clr(1'b0),
    .push(bk_valid), .push_pc(bk_pc), .push_target(bk_target), .push_taken(bk_taken),
    .pop(bk_pop), .nonempty(bk_ne),
    .head_pc(bk_h_pc), .head_target(bk_h_target), .head_taken(bk_h_taken),
    .drop_cnt(bk_drop_cnt)
  );

  nlp_uq_fifo #(.DEPTH(IF3_DEPTH)) u_if3_q (
    .clk(clk), .rst(rst), .clr(flush),
    .push(if3_valid), .push_pc(if3_pc), .push_target(if3_target), .push_taken(if3_taken),
    .pop(if3_pop), .nonempty(if3_ne),
    .head_pc(if3_h_pc), .head_target(if3_h_target), .head_taken(if3_h_taken),
    .drop_cnt(if3_drop_cnt)
  );

  always_comb begin
    upd_valid   = bk_ne || if3_ne;
    upd_from_bk = bk_ne;
    upd_pc      = bk_ne ? bk_h_pc     : if3_h_pc;
    upd_target  = bk_ne ? bk_h_target : if3_h_target;
    upd_taken   = bk_ne ? bk_h_taken  : if3_h_taken;
  end
endmodule
